// File: rtl/hilo_mul_ctrl.sv
// HI/LO register owner and 32-iteration shift-add multiply sequencer for the EX stage.
// Define HILO_MUL_SIGNED_EN to make op=01 a signed MULT; otherwise op=01 behaves as MULTU.
module hilo_mul_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        rd_hilo,
    input  logic        abort,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] product_q, product_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [32:0] sum;
    logic [63:0] prod_next;
    logic [63:0] commit;
`ifdef HILO_MUL_SIGNED_EN
    logic        neg_q, neg_d;
`endif

    // The product LSB is shifted out on every iteration and never read back.
    logic unused_prod_lsb;
    assign unused_prod_lsb = product_q[0];

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef HILO_MUL_SIGNED_EN
        neg_d     = neg_q;
`endif

        sum       = {1'b0, product_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_next = {sum, product_q[31:1]};
        commit    = prod_next;
`ifdef HILO_MUL_SIGNED_EN
        if (neg_q) begin
            commit = -prod_next;
        end
`endif

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    case (op)
                        2'b00, 2'b01: begin
                            mcand_d   = dataA;
                            mplier_d  = dataB;
                            product_d = '0;
                            count_d   = '0;
                            state_d   = StCalc;
`ifdef HILO_MUL_SIGNED_EN
                            neg_d     = 1'b0;
                            if (op == 2'b01) begin
                                // Iterate on magnitudes; the sign is reapplied at commit.
                                mcand_d  = dataA[31] ? -dataA : dataA;
                                mplier_d = dataB[31] ? -dataB : dataB;
                                neg_d    = dataA[31] ^ dataB[31];
                            end
`endif
                        end
                        2'b10:   hi_d = dataA;
                        default: lo_d = dataA;
                    endcase
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    product_d = prod_next;
                    mplier_d  = mplier_q >> 1;
                    count_d   = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_d = StDone;
                        hi_d    = commit[63:32];
                        lo_d    = commit[31:0];
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef HILO_MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef HILO_MUL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign stall = busy & (start | rd_hilo);

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Scoreboarded bench for hilo_mul_ctrl: expected HI/LO commits are queued at issue and
// checked by a monitor on each done pulse; timing and stall behaviour are checked inline.
module tb_hilo_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, rd_hilo, abort;
    logic [1:0]  op;
    logic [31:0] dataA, dataB;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    hilo_mul_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .dataA   (dataA),
        .dataB   (dataB),
        .rd_hilo (rd_hilo),
        .abort   (abort),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no pulse", hi, lo);
            end else begin
                chk("commit_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Entered just after a negedge. Issues one request (holding it while stalled), then
    // walks the busy window applying optional side stimulus at busy-cycle index n.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int rd_from, input int mth_from, input int abort_at,
                       input int reset_at, output int n, output int done_at, output int st);
        int w;
        start = 1'b1;
        op    = o;
        dataA = a;
        dataB = b;
        w     = 0;
        #1;
        while (stall && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        n       = 0;
        done_at = 0;
        st      = 0;
        while (busy && n < 100) begin
            n++;
            if (done) done_at = n;
            if (n == abort_at) abort = 1'b1;
            if (n == reset_at) reset = 1'b1;
            if (n >= rd_from) rd_hilo = 1'b1;
            if (n >= mth_from) begin
                start = 1'b1;
                op    = 2'b10;
                dataA = 32'h0000AAAA;
            end
            #1;
            if (stall) st++;
            @(negedge clk);
        end
        abort = 1'b0;
        reset = 1'b0;
        #1;
        chk("stall_when_idle", {63'd0, stall}, 64'd0);
        rd_hilo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, done_at, st;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        dataA   = '0;
        dataB   = '0;
        rd_hilo = 1'b0;
        abort   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, stall}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Max unsigned operands.
        exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1000, 1000, 0, 0, n, done_at, st);
        chk("max_busy_cycles", n, 33);
        chk("max_done_cycle", done_at, 33);

        // Zero multiplier takes full latency, then an immediate back-to-back request.
        exp_q.push_back(64'd0);
        run(2'b00, 32'h00012345, 32'h0, 1000, 1000, 0, 0, n, done_at, st);
        chk("zero_busy_cycles", n, 33);
        exp_q.push_back(64'd42);
        run(2'b00, 32'd7, 32'd6, 1000, 1000, 0, 0, n, done_at, st);
        chk("b2b_busy_cycles", n, 33);

        // MTLO in IDLE.
        run(2'b11, 32'h12345678, 32'h0, 1000, 1000, 0, 0, n, done_at, st);
        chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h12345678});
        chk("mtlo_no_busy", n, 0);

        // MFHI/MFLO pending from busy cycle 5 stalls through DONE.
        exp_q.push_back(64'd15);
        run(2'b00, 32'd3, 32'd5, 5, 1000, 0, 0, n, done_at, st);
        chk("rd_stall_cycles", st, 29);

        // Abort mid-CALC leaves HI/LO untouched.
        run(2'b00, 32'd10, 32'd10, 1000, 1000, 10, 0, n, done_at, st);
        chk("abort_busy_cycles", n, 10);
        chk("abort_hilo_kept", {hi, lo}, 64'd15);

        // Reset mid-CALC clears everything at once.
        run(2'b00, 32'h0000FFFF, 32'h0000FFFF, 1000, 1000, 0, 20, n, done_at, st);
        chk("reset_busy_cycles", n, 20);
        chk("reset_mid_hilo", {hi, lo}, 64'd0);

        // MTHI presented during busy is held off, then lands once idle.
        exp_q.push_back(64'd6);
        run(2'b00, 32'd2, 32'd3, 1000, 8, 0, 0, n, done_at, st);
        chk("mthi_stall_cycles", st, 26);
        chk("mthi_hi_before", {32'd0, hi}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("mthi_held_write", {hi, lo}, {32'h0000AAAA, 32'd6});

        // op=01 with -3 x 5.
`ifdef HILO_MUL_SIGNED_EN
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
`else
        exp_q.push_back({32'h00000004, 32'hFFFFFFF1});
`endif
        run(2'b01, 32'hFFFFFFFD, 32'd5, 1000, 1000, 0, 0, n, done_at, st);
        chk("mult_busy_cycles", n, 33);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
